// File: rtl/addsub_serial.sv
// addsub_serial: multi-cycle add/subtract unit that reuses one CHUNK-bit slice
// WIDTH/CHUNK times, LSB chunk first. It reports carry/borrow-out and signed
// overflow.
// Optional feature macro: ADDSUB_SATURATE_EN. When it is defined, an
// overflowing Result is clamped to the most positive or most negative value.
module addsub_serial #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic             Cout,
    output logic             Ovf
);

    localparam int unsigned N     = WIDTH / CHUNK;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW    = CHUNK + 1;

`ifdef ADDSUB_SATURATE_EN
    localparam logic [WIDTH-1:0] MIN_NEG = WIDTH'(1) << (WIDTH - 1);
    localparam logic [WIDTH-1:0] MAX_POS = ~MIN_NEG;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;      // operand A, shifted right one chunk per RUN cycle
    logic [WIDTH-1:0] b_sh;      // operand B, shifted right one chunk per RUN cycle
    logic [WIDTH-1:0] acc;       // partial result, filled from the top down
    logic             op_q;
    logic             carry_q;   // carry (add) or borrow (sub) between chunks
    logic             a_msb;
    logic             b_msb;
    logic [CNT_W-1:0] cnt;

    logic [CW-1:0]    slice;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] res_final;
    logic             last;
    logic             ovf_calc;

    // One chunk of add/subtract. The extra top bit holds the carry-out or borrow-out.
    always_comb begin
        slice = '0;
        if (op_q) begin
            slice = {1'b0, a_sh[CHUNK-1:0]} - {1'b0, b_sh[CHUNK-1:0]} - CW'(carry_q);
        end else begin
            slice = {1'b0, a_sh[CHUNK-1:0]} + {1'b0, b_sh[CHUNK-1:0]} + CW'(carry_q);
        end
    end

    // Shift the new chunk into the top of the accumulator and detect overflow.
    // On the last chunk, acc_next is the full wrapped result.
    always_comb begin
        acc_next = (acc >> CHUNK) | (WIDTH'(slice[CHUNK-1:0]) << (WIDTH - CHUNK));
        last     = (cnt == CNT_W'(N - 1));
        if (op_q) begin
            ovf_calc = (a_msb != b_msb) && (acc_next[WIDTH-1] != a_msb);
        end else begin
            ovf_calc = (a_msb == b_msb) && (acc_next[WIDTH-1] != a_msb);
        end
`ifdef ADDSUB_SATURATE_EN
        if (ovf_calc) begin
            res_final = a_msb ? MIN_NEG : MAX_POS;
        end else begin
            res_final = acc_next;
        end
`else
        res_final = acc_next;
`endif
    end

    // Control FSM, operand/accumulator registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            Result  <= '0;
            Cout    <= 1'b0;
            Ovf     <= 1'b0;
            a_sh    <= '0;
            b_sh    <= '0;
            acc     <= '0;
            op_q    <= 1'b0;
            carry_q <= 1'b0;
            a_msb   <= 1'b0;
            b_msb   <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state   <= RUN;
                        busy    <= 1'b1;
                        a_sh    <= A;
                        b_sh    <= B;
                        op_q    <= op;
                        carry_q <= Cin;
                        a_msb   <= A[WIDTH-1];
                        b_msb   <= B[WIDTH-1];
                        acc     <= '0;
                        cnt     <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sh    <= a_sh >> CHUNK;
                    b_sh    <= b_sh >> CHUNK;
                    acc     <= acc_next;
                    carry_q <= slice[CHUNK];
                    cnt     <= cnt + CNT_W'(1);
                    if (last) begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        Result <= res_final;
                        Cout   <= slice[CHUNK];
                        Ovf    <= ovf_calc;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_serial.sv
// Testbench for addsub_serial. A 16/4 instance runs the main scenarios and an
// 8/1 instance runs the bit-serial case. Expected results come from a
// full-width arithmetic model and are queued when a request is driven.
module tb_addsub_serial;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, op, cin;
    logic [15:0] a, b;
    logic        busy, done, cout, ovf;
    logic [15:0] result;

    logic        start8, op8, cin8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, cout8, ovf8;
    logic [7:0]  result8;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [15:0] res;
        logic        cout;
        logic        ovf;
    } exp_t;

    exp_t q[$];
    exp_t q8[$];

    always #5 clk = ~clk;

    addsub_serial #(.WIDTH(16), .CHUNK(4)) u_dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .A(a), .B(b), .Cin(cin),
        .busy(busy), .done(done), .Result(result), .Cout(cout), .Ovf(ovf)
    );

    addsub_serial #(.WIDTH(8), .CHUNK(1)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8), .A(a8), .B(b8), .Cin(cin8),
        .busy(busy8), .done(done8), .Result(result8), .Cout(cout8), .Ovf(ovf8)
    );

    // Full-width reference for a w-bit add/subtract.
    function automatic exp_t model(input int w, input logic o, input logic [15:0] x,
                                   input logic [15:0] y, input logic c);
        logic [31:0] full, mask, half;
        logic        xm, ym, rm;
        exp_t        e;
        mask = (32'd1 << w) - 32'd1;
        half = 32'd1 << (w - 1);
        if (o) full = {16'd0, x} - {16'd0, y} - {31'd0, c};
        else   full = {16'd0, x} + {16'd0, y} + {31'd0, c};
        e.res  = 16'(full & mask);
        e.cout = full[w];
        xm = x[w-1];
        ym = y[w-1];
        rm = full[w-1];
        e.ovf = o ? ((xm != ym) && (rm != xm)) : ((xm == ym) && (rm != xm));
`ifdef ADDSUB_SATURATE_EN
        if (e.ovf) e.res = xm ? 16'(half) : 16'(half - 32'd1);
`endif
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one request on the 16-bit unit and queue its expected result.
    task automatic issue(input logic o, input logic [15:0] x, input logic [15:0] y,
                         input logic c);
        @(negedge clk);
        op = o; a = x; b = y; cin = c; start = 1'b1;
        q.push_back(model(16, o, x, y, c));
        @(posedge clk);
        #1 start = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'd1);
    endtask

    // Wait for done (bounded), check latency and results, then check the pulse drops.
    task automatic wait_done(input int lat, input string tag);
        int   cyc  = 0;
        bit   seen = 1'b0;
        exp_t e;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else cyc++;
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_latency"}, 32'(cyc), 32'(lat));
        chk({tag, "_busy_low"}, 32'(busy), 32'd0);
        chk({tag, "_sb_nonempty"}, 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
            e = q.pop_front();
            chk({tag, "_result"}, 32'(result), 32'(e.res));
            chk({tag, "_cout"}, 32'(cout), 32'(e.cout));
            chk({tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
            @(negedge clk);
            chk({tag, "_done_pulse"}, 32'(done), 32'd0);
            chk({tag, "_result_hold"}, 32'(result), 32'(e.res));
        end
    endtask

    initial begin
        exp_t e;
        int   cyc;
        int   dcount;
        bit   seen;

        rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0; cin = 1'b0;
        start8 = 1'b0; op8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);

        // Directed cases from the test plan.
        issue(1'b1, 16'h1234, 16'h0234, 1'b0); wait_done(4, "sub_basic");
        issue(1'b1, 16'h0000, 16'h0001, 1'b0); wait_done(4, "sub_borrow");
        issue(1'b0, 16'hFFFF, 16'h0000, 1'b1); wait_done(4, "add_carry");
        issue(1'b0, 16'h7FFF, 16'h0001, 1'b0); wait_done(4, "add_ovf");
        issue(1'b1, 16'h8000, 16'h0001, 1'b0); wait_done(4, "sub_ovf");
        issue(1'b0, 16'h8000, 16'h8000, 1'b0); wait_done(4, "add_negovf");
        for (int i = 0; i < 4; i++) begin
            issue(1'(i), 16'($urandom), 16'($urandom), 1'($urandom));
            wait_done(4, "rand");
        end

        // Start held high while operands change mid-RUN, then back-to-back accept in DONE.
        @(negedge clk);
        op = 1'b0; a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
        q.push_back(model(16, 1'b0, 16'h1111, 16'h2222, 1'b0));
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("b2b_busy_run", 32'(busy), 32'd1);
            a = 16'($urandom); b = 16'($urandom); op = 1'($urandom); cin = 1'($urandom);
        end
        @(negedge clk);
        chk("b2b_first_done", 32'(done), 32'd1);
        e = q.pop_front();
        chk("b2b_first_result", 32'(result), 32'(e.res));
        chk("b2b_first_cout", 32'(cout), 32'(e.cout));
        op = 1'b1; a = 16'h0050; b = 16'h0051; cin = 1'b1;
        q.push_back(model(16, 1'b1, 16'h0050, 16'h0051, 1'b1));
        @(posedge clk);
        #1 start = 1'b0;
        chk("b2b_second_busy", 32'(busy), 32'd1);
        wait_done(4, "b2b_second");

        // Reset on the second RUN edge aborts the operation without a done pulse.
        issue(1'b0, 16'h1357, 16'h2468, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        void'(q.pop_back());
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        chk("abort_ovf", 32'(ovf), 32'd0);
        dcount = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("abort_no_done", 32'(dcount), 32'd0);
        issue(1'b1, 16'h4000, 16'h0FFF, 1'b0); wait_done(4, "after_abort");

        // Bit-serial instance: 8 chunks of 1 bit.
        @(negedge clk);
        op8 = 1'b1; a8 = 8'h05; b8 = 8'h07; cin8 = 1'b0; start8 = 1'b1;
        q8.push_back(model(8, 1'b1, 16'h0005, 16'h0007, 1'b0));
        @(posedge clk);
        #1 start8 = 1'b0;
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            if (done8) seen = 1'b1;
            else cyc++;
        end
        chk("w8_done_seen", 32'(seen), 32'd1);
        chk("w8_latency", 32'(cyc), 32'd8);
        e = q8.pop_front();
        chk("w8_result", 32'(result8), 32'(e.res));
        chk("w8_cout", 32'(cout8), 32'(e.cout));
        chk("w8_ovf", 32'(ovf8), 32'(e.ovf));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
